// File: rtl/psimd_exc_pkg.sv
// Shared types and constants for the PSIMD exception-flag accumulation path.
// Flag bit order everywhere is {NV,DZ,OF,UF,NX}.
package psimd_exc_pkg;

  localparam int NUM_LANES = 4;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  typedef logic [4:0] fflags_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } trap_state_t;

endpackage

// File: rtl/psimd_lane_prio_enc.sv
// Lowest-index priority encoder over the PSIMD lanes, with a found flag.
module psimd_lane_prio_enc #(
  parameter int NUM_LANES = psimd_exc_pkg::NUM_LANES
) (
  input  logic [NUM_LANES-1:0] req,
  output logic [1:0]           idx,
  output logic                 found
);

  // Scan from the top down so the lowest set lane wins.
  always_comb begin
    idx   = 2'd0;
    found = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psimd_fflags_accum.sv
// Accumulates masked per-lane PSIMD exception flags into sticky fflags,
// counts flagged results and raises a backpressuring trap request.
module psimd_fflags_accum
  import psimd_exc_pkg::*;
#(
  parameter int NUM_LANES = psimd_exc_pkg::NUM_LANES,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic [NUM_LANES-1:0] invalid,
  input  logic [NUM_LANES-1:0] div_by_zero,
  input  logic [NUM_LANES-1:0] overflow,
  input  logic [NUM_LANES-1:0] underflow,
  input  logic [NUM_LANES-1:0] inexact,
  input  logic                 csr_rd_en,
  input  logic                 csr_wr_en,
  input  logic [4:0]           csr_wdata,
  output logic [4:0]           csr_rdata,
  output logic                 csr_rvalid,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     exc_count,
  input  logic [4:0]           trap_en,
  output logic                 trap_req,
  input  logic                 trap_ack,
  output logic [4:0]           trap_cause,
  output logic [1:0]           trap_lane
);

  trap_state_t          state, state_next;
  fflags_t              fflags;
  fflags_t              new_flags;
  logic                 acc;
  logic [NUM_LANES-1:0] lane_hit;
  logic [1:0]           hit_lane;
  logic                 hit_found;
  logic                 trap_fire;

  assign res_ready = (state == IDLE);
  assign trap_req  = (state == PENDING);
  assign acc       = res_valid & res_ready;

  always_comb begin
    new_flags = '0;
    if (acc) begin
      new_flags[FLG_NV] = |(invalid     & lane_mask);
      new_flags[FLG_DZ] = |(div_by_zero & lane_mask);
      new_flags[FLG_OF] = |(overflow    & lane_mask);
      new_flags[FLG_UF] = |(underflow   & lane_mask);
      new_flags[FLG_NX] = |(inexact     & lane_mask);
    end
  end

  // A lane hits when it is active and carries at least one trap-enabled flag.
  always_comb begin
    lane_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_hit[i] = lane_mask[i] &
                    ((invalid[i]     & trap_en[FLG_NV]) |
                     (div_by_zero[i] & trap_en[FLG_DZ]) |
                     (overflow[i]    & trap_en[FLG_OF]) |
                     (underflow[i]   & trap_en[FLG_UF]) |
                     (inexact[i]     & trap_en[FLG_NX]));
    end
  end

  psimd_lane_prio_enc #(
    .NUM_LANES(NUM_LANES)
  ) u_lane_prio (
    .req  (lane_hit),
    .idx  (hit_lane),
    .found(hit_found)
  );

  // Any hitting lane implies |(new_flags & trap_en) for an accepted result.
  assign trap_fire = acc & hit_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trap_fire) state_next = PENDING;
      PENDING: if (trap_ack)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_cause <= '0;
      trap_lane  <= '0;
    end else if (state == IDLE && trap_fire) begin
      trap_cause <= new_flags & trap_en;
      trap_lane  <= hit_lane;
    end
  end

  // CSR write lands first, then this result's flags are ORed on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags <= '0;
    end else begin
      fflags <= (csr_wr_en ? csr_wdata : fflags) | new_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_rd_en;
      if (csr_rd_en) csr_rdata <= fflags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_count <= '0;
    end else if (cnt_clr) begin
      exc_count <= '0;
    end else if (acc && (|new_flags) && (exc_count != {CNT_W{1'b1}})) begin
      exc_count <= exc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_psimd_fflags_accum.sv
// Directed self-checking bench for psimd_fflags_accum (counter narrowed to 4 bits
// so saturation is reachable quickly).
module tb_psimd_fflags_accum;

  localparam int NL    = 4;
  localparam int CNT_W = 4;

  logic          clk;
  logic          rst;
  logic          res_valid;
  logic          res_ready;
  logic [NL-1:0] lane_mask;
  logic [NL-1:0] invalid;
  logic [NL-1:0] div_by_zero;
  logic [NL-1:0] overflow;
  logic [NL-1:0] underflow;
  logic [NL-1:0] inexact;
  logic          csr_rd_en;
  logic          csr_wr_en;
  logic [4:0]    csr_wdata;
  logic [4:0]    csr_rdata;
  logic          csr_rvalid;
  logic          cnt_clr;
  logic [CNT_W-1:0] exc_count;
  logic [4:0]    trap_en;
  logic          trap_req;
  logic          trap_ack;
  logic [4:0]    trap_cause;
  logic [1:0]    trap_lane;

  int checks = 0;
  int errors = 0;

  psimd_fflags_accum #(
    .NUM_LANES(NL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .lane_mask  (lane_mask),
    .invalid    (invalid),
    .div_by_zero(div_by_zero),
    .overflow   (overflow),
    .underflow  (underflow),
    .inexact    (inexact),
    .csr_rd_en  (csr_rd_en),
    .csr_wr_en  (csr_wr_en),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_rvalid (csr_rvalid),
    .cnt_clr    (cnt_clr),
    .exc_count  (exc_count),
    .trap_en    (trap_en),
    .trap_req   (trap_req),
    .trap_ack   (trap_ack),
    .trap_cause (trap_cause),
    .trap_lane  (trap_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    res_valid = 0; lane_mask = '0; invalid = '0; div_by_zero = '0;
    overflow = '0; underflow = '0; inexact = '0;
    csr_rd_en = 0; csr_wr_en = 0; csr_wdata = '0;
    cnt_clr = 0; trap_en = '0; trap_ack = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  // One-cycle read request; returns the sampled data and valid bit.
  task automatic read_fflags(output logic [4:0] data, output logic vld);
    csr_rd_en = 1;
    tick();
    csr_rd_en = 0;
    data = csr_rdata;
    vld  = csr_rvalid;
  endtask

  task automatic test_reset();
    logic [4:0] d; logic v;
    idle_inputs();
    rst = 1;
    #12;
    checks++;
    if (trap_req !== 1'b0 || exc_count !== 4'd0 || csr_rvalid !== 1'b0 ||
        csr_rdata !== 5'd0 || trap_cause !== 5'd0 || trap_lane !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: trap_req=%b exc_count=%0d rvalid=%b rdata=%b cause=%b lane=%0d, required all zero",
               trap_req, exc_count, csr_rvalid, csr_rdata, trap_cause, trap_lane);
    end
    @(negedge clk);
    rst = 0;
    tick();
    checks++;
    if (res_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: res_ready=%b required 1", res_ready);
    end
    read_fflags(d, v);
    checks++;
    if (d !== 5'd0 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_fflags: rdata=%b rvalid=%b required 00000/1", d, v);
    end
  endtask

  task automatic test_accept_read();
    logic [4:0] d; logic v;
    reset_dut();
    res_valid = 1; lane_mask = 4'b1111; inexact = 4'b0010;
    tick();
    idle_inputs();
    checks++;
    if (exc_count !== 4'd1) begin
      errors++;
      $display("FAIL nx_count: exc_count=%0d required 1", exc_count);
    end
    tick();
    read_fflags(d, v);
    checks++;
    if (d !== 5'b00001 || v !== 1'b1) begin
      errors++;
      $display("FAIL nx_read: rdata=%b rvalid=%b required 00001/1", d, v);
    end
    tick();
    checks++;
    if (csr_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_pulse: rvalid=%b required 0", csr_rvalid);
    end
  endtask

  task automatic test_lane_mask();
    logic [4:0] d; logic v;
    reset_dut();
    res_valid = 1; lane_mask = 4'b0111; overflow = 4'b1000;
    tick();
    res_valid = 0;
    checks++;
    if (exc_count !== 4'd0) begin
      errors++;
      $display("FAIL masked_count: exc_count=%0d required 0", exc_count);
    end
    read_fflags(d, v);
    checks++;
    if (d !== 5'b00000) begin
      errors++;
      $display("FAIL masked_fflags: rdata=%b required 00000", d);
    end
    res_valid = 1; lane_mask = 4'b1111;
    tick();
    idle_inputs();
    read_fflags(d, v);
    checks++;
    if (d !== 5'b00100 || exc_count !== 4'd1) begin
      errors++;
      $display("FAIL of_fflags: rdata=%b exc_count=%0d required 00100/1", d, exc_count);
    end
    // Empty lane mask: accepted, no flags, no trap.
    trap_en = 5'b11111; res_valid = 1; lane_mask = 4'b0000; invalid = 4'b1111;
    tick();
    idle_inputs();
    checks++;
    if (trap_req !== 1'b0 || exc_count !== 4'd1) begin
      errors++;
      $display("FAIL empty_mask: trap_req=%b exc_count=%0d required 0/1", trap_req, exc_count);
    end
  endtask

  task automatic test_trap();
    logic [4:0] d; logic v;
    reset_dut();
    trap_en = 5'b01000; res_valid = 1; lane_mask = 4'b1111; div_by_zero = 4'b1100;
    tick();
    checks++;
    if (trap_req !== 1'b1 || trap_cause !== 5'b01000 || trap_lane !== 2'd2 || res_ready !== 1'b0) begin
      errors++;
      $display("FAIL trap_raise: req=%b cause=%b lane=%0d ready=%b required 1/01000/2/0",
               trap_req, trap_cause, trap_lane, res_ready);
    end
    div_by_zero = '0; invalid = 4'b1111;
    tick();
    checks++;
    if (trap_req !== 1'b1 || res_ready !== 1'b0 || exc_count !== 4'd1) begin
      errors++;
      $display("FAIL trap_stall: req=%b ready=%b exc_count=%0d required 1/0/1", trap_req, res_ready, exc_count);
    end
    trap_ack = 1;
    tick();
    trap_ack = 0; res_valid = 0; invalid = '0;
    checks++;
    if (trap_req !== 1'b0 || res_ready !== 1'b1 || exc_count !== 4'd1) begin
      errors++;
      $display("FAIL trap_ack: req=%b ready=%b exc_count=%0d required 0/1/1", trap_req, res_ready, exc_count);
    end
    read_fflags(d, v);
    checks++;
    if (d !== 5'b01000) begin
      errors++;
      $display("FAIL trap_fflags: rdata=%b required 01000", d);
    end
    trap_ack = 1;
    tick();
    trap_ack = 0;
    checks++;
    if (trap_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: trap_req=%b required 0", trap_req);
    end
    // Second trap on lane 1; trap_en changes while pending must not disturb cause.
    trap_en = 5'b11111; res_valid = 1; lane_mask = 4'b1110; overflow = 4'b0011;
    tick();
    res_valid = 0; overflow = '0; trap_en = 5'b00000;
    tick();
    checks++;
    if (trap_req !== 1'b1 || trap_cause !== 5'b00100 || trap_lane !== 2'd1) begin
      errors++;
      $display("FAIL trap_hold: req=%b cause=%b lane=%0d required 1/00100/1", trap_req, trap_cause, trap_lane);
    end
    read_fflags(d, v);
    checks++;
    if (d !== 5'b01100 || v !== 1'b1) begin
      errors++;
      $display("FAIL pending_read: rdata=%b rvalid=%b required 01100/1", d, v);
    end
    idle_inputs();
  endtask

  task automatic test_write_read_accept();
    logic [4:0] d; logic v;
    reset_dut();
    res_valid = 1; lane_mask = 4'b0001; inexact = 4'b0001;
    tick();
    inexact = '0; lane_mask = 4'b1111; invalid = 4'b0001;
    csr_wr_en = 1; csr_wdata = 5'b00000; csr_rd_en = 1;
    tick();
    idle_inputs();
    checks++;
    if (csr_rdata !== 5'b00001 || csr_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rw_old: rdata=%b rvalid=%b required 00001/1", csr_rdata, csr_rvalid);
    end
    read_fflags(d, v);
    checks++;
    if (d !== 5'b10000) begin
      errors++;
      $display("FAIL rw_new: rdata=%b required 10000", d);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    res_valid = 1; lane_mask = 4'b1111; inexact = 4'b1111;
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if (exc_count !== 4'd15) begin
      errors++;
      $display("FAIL count_sat: exc_count=%0d required 15", exc_count);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++;
    if (exc_count !== 4'd0) begin
      errors++;
      $display("FAIL count_clr: exc_count=%0d required 0", exc_count);
    end
    tick();
    idle_inputs();
    checks++;
    if (exc_count !== 4'd1) begin
      errors++;
      $display("FAIL count_restart: exc_count=%0d required 1", exc_count);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] d; logic v;
    reset_dut();
    trap_en = 5'b10000; res_valid = 1; lane_mask = 4'b1111; invalid = 4'b0001;
    tick();
    res_valid = 0; invalid = '0;
    checks++;
    if (trap_req !== 1'b1 || exc_count !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset: req=%b exc_count=%0d required 1/1", trap_req, exc_count);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (trap_req !== 1'b0 || exc_count !== 4'd0 || trap_cause !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: req=%b exc_count=%0d cause=%b required 0/0/00000",
               trap_req, exc_count, trap_cause);
    end
    #4;
    rst = 0;
    idle_inputs();
    tick();
    checks++;
    if (res_ready !== 1'b1 || trap_req !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ready=%b req=%b required 1/0", res_ready, trap_req);
    end
    read_fflags(d, v);
    checks++;
    if (d !== 5'b00000) begin
      errors++;
      $display("FAIL reset_clears_fflags: rdata=%b required 00000", d);
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_accept_read();
    test_lane_mask();
    test_trap();
    test_write_read_accept();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
